// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU opcodes, branch types, CCR bit positions
// and the operand forwarding selector used by the execute stage.
package cpu_pkg;

   localparam int DW = 8;
   localparam int RW = 2;

   localparam logic [3:0] ALU_OP_PASS_A = 4'h0;
   localparam logic [3:0] ALU_OP_PASS_B = 4'h1;
   localparam logic [3:0] ALU_OP_ADD    = 4'h2;
   localparam logic [3:0] ALU_OP_SUB    = 4'h3;
   localparam logic [3:0] ALU_OP_AND    = 4'h4;
   localparam logic [3:0] ALU_OP_OR     = 4'h5;
   localparam logic [3:0] ALU_OP_RLC    = 4'h6;
   localparam logic [3:0] ALU_OP_RRC    = 4'h7;
   localparam logic [3:0] ALU_OP_SETC   = 4'h8;
   localparam logic [3:0] ALU_OP_CLRC   = 4'h9;
   localparam logic [3:0] ALU_OP_NOT    = 4'hA;
   localparam logic [3:0] ALU_OP_NEG    = 4'hB;
   localparam logic [3:0] ALU_OP_INC    = 4'hC;
   localparam logic [3:0] ALU_OP_DEC    = 4'hD;

   typedef enum logic [1:0] {
      BTYPE_NONE   = 2'b00,
      BTYPE_COND   = 2'b01,
      BTYPE_UNCOND = 2'b10,
      BTYPE_RSVD   = 2'b11
   } btype_e;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

   // The younger writer (EX/MEM) wins over MEM/WB when both target the same register.
   function automatic logic [DW-1:0] fwd_sel(
      input logic [RW-1:0] addr,
      input logic [DW-1:0] id_val,
      input logic          ex_we,
      input logic [RW-1:0] ex_rd,
      input logic [DW-1:0] ex_val,
      input logic          wb_we,
      input logic [RW-1:0] wb_rd,
      input logic [DW-1:0] wb_val
   );
      logic [DW-1:0] sel;
      sel = id_val;
      if (ex_we && (ex_rd == addr)) begin
         sel = ex_val;
      end else if (wb_we && (wb_rd == addr)) begin
         sel = wb_val;
      end
      return sel;
   endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register / forwarding sources and the execute stage, plus
// the execute-stage results toward EX/MEM and fetch.
interface ex_stage_if;
   import cpu_pkg::*;

   logic [3:0]    alu_op;
   logic          alu_src;
   logic          update_flags;
   logic [1:0]    btype;
   logic [DW-1:0] ra_val;
   logic [DW-1:0] rb_val;
   logic [RW-1:0] ra;
   logic [RW-1:0] rb;
   logic [DW-1:0] imm;
   logic          exmem_we;
   logic [RW-1:0] exmem_rd;
   logic [DW-1:0] exmem_val;
   logic          memwb_we;
   logic [RW-1:0] memwb_rd;
   logic [DW-1:0] memwb_val;
   logic          int_save;
   logic          rti_restore;

   logic [DW-1:0] alu_result;
   logic [DW-1:0] store_data;
   logic [3:0]    ccr;
   logic          branch_taken;
   logic [DW-1:0] branch_target;
   logic          flush_req;

   modport master (
      output alu_op, alu_src, update_flags, btype, ra_val, rb_val, ra, rb, imm,
             exmem_we, exmem_rd, exmem_val, memwb_we, memwb_rd, memwb_val,
             int_save, rti_restore,
      input  alu_result, store_data, ccr, branch_taken, branch_target, flush_req
   );

   modport slave (
      input  alu_op, alu_src, update_flags, btype, ra_val, rb_val, ra, rb, imm,
             exmem_we, exmem_rd, exmem_val, memwb_we, memwb_rd, memwb_val,
             int_save, rti_restore,
      output alu_result, store_data, ccr, branch_taken, branch_target, flush_req
   );

endinterface

// File: rtl/ex_alu.sv
// Combinational 8-bit ALU. c_valid_o / v_valid_o say whether the op defines C / V;
// when they are low the caller keeps the existing CCR bit.
module ex_alu import cpu_pkg::*; (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [3:0]    op_i,
   input  logic          cin_i,
   output logic [DW-1:0] y_o,
   output logic          c_o,
   output logic          v_o,
   output logic          c_valid_o,
   output logic          v_valid_o
);

   localparam logic [DW:0] ONE  = {{DW{1'b0}}, 1'b1};
   localparam logic [DW:0] ZERO = '0;

   // The 9th bit of each widened add/subtract is the carry or borrow out.
   always_comb begin
      y_o       = a_i;
      c_o       = 1'b0;
      v_o       = 1'b0;
      c_valid_o = 1'b0;
      v_valid_o = 1'b0;
      case (op_i)
         ALU_OP_PASS_A: y_o = a_i;
         ALU_OP_PASS_B: y_o = b_i;
         ALU_OP_ADD: begin
            {c_o, y_o} = {1'b0, a_i} + {1'b0, b_i};
            v_o        = (a_i[DW-1] == b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            c_valid_o  = 1'b1;
            v_valid_o  = 1'b1;
         end
         ALU_OP_SUB: begin
            {c_o, y_o} = {1'b0, a_i} - {1'b0, b_i};
            v_o        = (a_i[DW-1] != b_i[DW-1]) && (y_o[DW-1] != a_i[DW-1]);
            c_valid_o  = 1'b1;
            v_valid_o  = 1'b1;
         end
         ALU_OP_AND: y_o = a_i & b_i;
         ALU_OP_OR:  y_o = a_i | b_i;
         ALU_OP_RLC: begin
            y_o       = {a_i[DW-2:0], cin_i};
            c_o       = a_i[DW-1];
            c_valid_o = 1'b1;
         end
         ALU_OP_RRC: begin
            y_o       = {cin_i, a_i[DW-1:1]};
            c_o       = a_i[0];
            c_valid_o = 1'b1;
         end
         ALU_OP_SETC: begin
            c_o       = 1'b1;
            c_valid_o = 1'b1;
         end
         ALU_OP_CLRC: begin
            c_o       = 1'b0;
            c_valid_o = 1'b1;
         end
         ALU_OP_NOT: y_o = ~a_i;
         ALU_OP_NEG: begin
            {c_o, y_o} = ZERO - {1'b0, a_i};
            v_o        = a_i[DW-1] && y_o[DW-1];
            c_valid_o  = 1'b1;
            v_valid_o  = 1'b1;
         end
         ALU_OP_INC: begin
            {c_o, y_o} = {1'b0, a_i} + ONE;
            v_o        = !a_i[DW-1] && y_o[DW-1];
            c_valid_o  = 1'b1;
            v_valid_o  = 1'b1;
         end
         ALU_OP_DEC: begin
            {c_o, y_o} = {1'b0, a_i} - ONE;
            v_o        = a_i[DW-1] && !y_o[DW-1];
            c_valid_o  = 1'b1;
            v_valid_o  = 1'b1;
         end
         default: y_o = a_i;
      endcase
   end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, condition-code register with interrupt shadow,
// and same-cycle branch resolution that redirects fetch and flushes the front end.
module ex_stage import cpu_pkg::*; (
   input logic       clk,
   input logic       rst,
   ex_stage_if.slave bus
);

   logic [DW-1:0] op_a;
   logic [DW-1:0] op_b;
   logic [DW-1:0] fwd_rb;
   logic [DW-1:0] alu_y;
   logic          alu_c;
   logic          alu_v;
   logic          alu_c_valid;
   logic          alu_v_valid;
   logic [3:0]    ccr_q;
   logic [3:0]    ccr_d;
   logic [3:0]    shadow_q;
   logic [3:0]    shadow_d;
   logic          cond_taken;
   logic          taken;

   assign op_a   = fwd_sel(bus.ra, bus.ra_val, bus.exmem_we, bus.exmem_rd, bus.exmem_val,
                           bus.memwb_we, bus.memwb_rd, bus.memwb_val);
   assign fwd_rb = fwd_sel(bus.rb, bus.rb_val, bus.exmem_we, bus.exmem_rd, bus.exmem_val,
                           bus.memwb_we, bus.memwb_rd, bus.memwb_val);
   assign op_b   = bus.alu_src ? bus.imm : fwd_rb;

   ex_alu u_alu (
      .a_i       (op_a),
      .b_i       (op_b),
      .op_i      (bus.alu_op),
      .cin_i     (ccr_q[FLAG_C]),
      .y_o       (alu_y),
      .c_o       (alu_c),
      .v_o       (alu_v),
      .c_valid_o (alu_c_valid),
      .v_valid_o (alu_v_valid)
   );

   // Branch conditions test the committed CCR only; ra doubles as the flag selector.
   assign cond_taken = (bus.btype == BTYPE_COND) && ccr_q[bus.ra];
   assign taken      = cond_taken || (bus.btype == BTYPE_UNCOND);

   assign bus.alu_result    = alu_y;
   assign bus.store_data    = fwd_rb;
   assign bus.ccr           = ccr_q;
   assign bus.branch_taken  = taken;
   assign bus.branch_target = taken ? fwd_rb : '0;
   assign bus.flush_req     = taken;

   // Later assignments override earlier ones, giving rti > taken-cond clear > flag update.
   always_comb begin
      ccr_d    = ccr_q;
      shadow_d = shadow_q;
      if (bus.update_flags) begin
         ccr_d[FLAG_Z] = (alu_y == '0);
         ccr_d[FLAG_N] = alu_y[DW-1];
         if (alu_c_valid) ccr_d[FLAG_C] = alu_c;
         if (alu_v_valid) ccr_d[FLAG_V] = alu_v;
      end
      if (cond_taken) ccr_d[bus.ra] = 1'b0;
      if (bus.rti_restore) ccr_d = shadow_q;
      if (bus.int_save) shadow_d = ccr_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ccr_q    <= '0;
         shadow_q <= '0;
      end else begin
         ccr_q    <= ccr_d;
         shadow_q <= shadow_d;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized cycles checked
// against an arithmetic reference model of forwarding, ALU flags, CCR and shadow.
module tb_ex_stage;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [3:0] m_ccr = 4'h0;
   logic [3:0] m_shadow = 4'h0;

   ex_stage_if bus ();

   ex_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   function automatic int sx(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   function automatic int exp_fwd(input int addr, input int id_val);
      if (bus.exmem_we && int'(bus.exmem_rd) == addr) return int'(bus.exmem_val);
      if (bus.memwb_we && int'(bus.memwb_rd) == addr) return int'(bus.memwb_val);
      return id_val;
   endfunction

   // Reference ALU in plain integer arithmetic; overflow means the signed result leaves [-128,127].
   function automatic void model_alu(input int op, input int a, input int b, input int cin,
                                     output int y, output int c, output int cv,
                                     output int v, output int vv);
      int s;
      y = a; c = 0; cv = 0; v = 0; vv = 0;
      case (op)
         0: y = a;
         1: y = b;
         2: begin s = a + b; y = s % 256; c = (s > 255); cv = 1;
                  s = sx(a) + sx(b); v = (s > 127 || s < -128); vv = 1; end
         3: begin y = (a - b + 256) % 256; c = (a < b); cv = 1;
                  s = sx(a) - sx(b); v = (s > 127 || s < -128); vv = 1; end
         4: y = a & b;
         5: y = a | b;
         6: begin y = (a * 2) % 256 + cin; c = (a >= 128); cv = 1; end
         7: begin y = cin * 128 + a / 2; c = a % 2; cv = 1; end
         8: begin y = a; c = 1; cv = 1; end
         9: begin y = a; c = 0; cv = 1; end
         10: y = 255 - a;
         11: begin y = (256 - a) % 256; c = (a != 0); cv = 1; v = (-sx(a) > 127); vv = 1; end
         12: begin y = (a + 1) % 256; c = (a == 255); cv = 1; v = (sx(a) + 1 > 127); vv = 1; end
         13: begin y = (a + 255) % 256; c = (a == 0); cv = 1; v = (sx(a) - 1 < -128); vv = 1; end
         default: y = a;
      endcase
   endfunction

   function automatic int exp_result();
      int a, b, y, c, cv, v, vv;
      a = exp_fwd(int'(bus.ra), int'(bus.ra_val));
      b = bus.alu_src ? int'(bus.imm) : exp_fwd(int'(bus.rb), int'(bus.rb_val));
      model_alu(int'(bus.alu_op), a, b, int'(m_ccr[2]), y, c, cv, v, vv);
      return y;
   endfunction

   function automatic logic exp_taken();
      return (bus.btype == 2'd2) || (bus.btype == 2'd1 && m_ccr[bus.ra]);
   endfunction

   task automatic idle_inputs();
      bus.alu_op = 4'h0; bus.alu_src = 1'b0; bus.update_flags = 1'b0; bus.btype = 2'd0;
      bus.ra_val = 8'h00; bus.rb_val = 8'h00; bus.ra = 2'd0; bus.rb = 2'd0; bus.imm = 8'h00;
      bus.exmem_we = 1'b0; bus.exmem_rd = 2'd0; bus.exmem_val = 8'h00;
      bus.memwb_we = 1'b0; bus.memwb_rd = 2'd0; bus.memwb_val = 8'h00;
      bus.int_save = 1'b0; bus.rti_restore = 1'b0;
   endtask

   // Advance one clock: apply the CCR/shadow rules to the model, then sample 1 time unit after the edge.
   task automatic tick();
      int a, b, y, c, cv, v, vv;
      logic [3:0] nxt;
      logic       save;
      a = exp_fwd(int'(bus.ra), int'(bus.ra_val));
      b = bus.alu_src ? int'(bus.imm) : exp_fwd(int'(bus.rb), int'(bus.rb_val));
      model_alu(int'(bus.alu_op), a, b, int'(m_ccr[2]), y, c, cv, v, vv);
      nxt = m_ccr;
      if (bus.update_flags) begin
         nxt[0] = (y == 0);
         nxt[1] = (y >= 128);
         if (cv != 0) nxt[2] = (c != 0);
         if (vv != 0) nxt[3] = (v != 0);
      end
      if (bus.btype == 2'd1 && m_ccr[bus.ra]) nxt[bus.ra] = 1'b0;
      if (bus.rti_restore) nxt = m_shadow;
      save = bus.int_save;
      @(posedge clk);
      #1;
      if (save) m_shadow = m_ccr;
      m_ccr = nxt;
   endtask

   task automatic do_add(input logic [7:0] a, input logic [7:0] b);
      idle_inputs();
      bus.alu_op = ALU_OP_ADD; bus.ra = 2'd0; bus.ra_val = a;
      bus.alu_src = 1'b1; bus.imm = b; bus.update_flags = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #12;
      checks++; if (bus.ccr !== 4'h0) begin errors++; $display("[TB] FAIL reset_ccr: got %b expected 0000", bus.ccr); end
      checks++; if (bus.alu_result !== 8'h00) begin errors++; $display("[TB] FAIL reset_result: got %h expected 00", bus.alu_result); end
      checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken: got %b expected 0", bus.branch_taken); end
      rst = 1'b1;
      m_ccr = 4'h0; m_shadow = 4'h0;
      tick();
      do_add(8'hFF, 8'h01);
      tick();
      idle_inputs(); bus.int_save = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'b0101) begin errors++; $display("[TB] FAIL pre_async_ccr: got %b expected 0101", bus.ccr); end
      do_add(8'h7F, 8'h01);
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bus.ccr !== 4'h0) begin errors++; $display("[TB] FAIL async_reset_ccr: got %b expected 0000", bus.ccr); end
      checks++; if (bus.alu_result !== 8'h80) begin errors++; $display("[TB] FAIL async_reset_result: got %h expected 80", bus.alu_result); end
      m_ccr = 4'h0; m_shadow = 4'h0;
      rst = 1'b1;
      idle_inputs(); bus.rti_restore = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'h0) begin errors++; $display("[TB] FAIL reset_shadow: got %b expected 0000", bus.ccr); end
   endtask

   task automatic test_forwarding();
      idle_inputs();
      bus.alu_op = ALU_OP_PASS_A; bus.ra = 2'd1; bus.ra_val = 8'h05;
      bus.exmem_we = 1'b1; bus.exmem_rd = 2'd1; bus.exmem_val = 8'h0A;
      bus.memwb_we = 1'b1; bus.memwb_rd = 2'd1; bus.memwb_val = 8'h0C;
      #1;
      checks++; if (bus.alu_result !== 8'h0A) begin errors++; $display("[TB] FAIL fwd_exmem: got %h expected 0A", bus.alu_result); end
      bus.exmem_we = 1'b0;
      #1;
      checks++; if (bus.alu_result !== 8'h0C) begin errors++; $display("[TB] FAIL fwd_memwb: got %h expected 0C", bus.alu_result); end
      bus.memwb_we = 1'b0;
      #1;
      checks++; if (bus.alu_result !== 8'h05) begin errors++; $display("[TB] FAIL fwd_none: got %h expected 05", bus.alu_result); end
      bus.alu_op = ALU_OP_PASS_B; bus.rb = 2'd2; bus.rb_val = 8'h11;
      bus.memwb_we = 1'b1; bus.memwb_rd = 2'd2; bus.memwb_val = 8'h22;
      bus.exmem_we = 1'b1; bus.exmem_rd = 2'd3; bus.exmem_val = 8'h44;
      bus.alu_src = 1'b1; bus.imm = 8'h33;
      #1;
      checks++; if (bus.alu_result !== 8'h33) begin errors++; $display("[TB] FAIL imm_operand: got %h expected 33", bus.alu_result); end
      checks++; if (bus.store_data !== 8'h22) begin errors++; $display("[TB] FAIL store_data_fwd: got %h expected 22", bus.store_data); end
      tick();
   endtask

   task automatic test_arith();
      do_add(8'h7F, 8'h01);
      #1;
      checks++; if (bus.alu_result !== 8'h80) begin errors++; $display("[TB] FAIL add_result: got %h expected 80", bus.alu_result); end
      tick();
      checks++; if (bus.ccr !== 4'b1010) begin errors++; $display("[TB] FAIL add_flags: got %b expected 1010", bus.ccr); end
      idle_inputs();
      bus.alu_op = ALU_OP_SUB; bus.ra_val = 8'h00; bus.alu_src = 1'b1; bus.imm = 8'h01; bus.update_flags = 1'b1;
      #1;
      checks++; if (bus.alu_result !== 8'hFF) begin errors++; $display("[TB] FAIL sub_result: got %h expected FF", bus.alu_result); end
      tick();
      checks++; if (bus.ccr !== 4'b0110) begin errors++; $display("[TB] FAIL sub_flags: got %b expected 0110", bus.ccr); end
      idle_inputs();
      bus.alu_op = ALU_OP_RLC; bus.ra_val = 8'h80; bus.update_flags = 1'b1;
      #1;
      checks++; if (bus.alu_result !== 8'h01) begin errors++; $display("[TB] FAIL rlc_result: got %h expected 01", bus.alu_result); end
      tick();
      checks++; if (bus.ccr !== 4'b0100) begin errors++; $display("[TB] FAIL rlc_flags: got %b expected 0100", bus.ccr); end
   endtask

   task automatic test_branch();
      do_add(8'hFF, 8'h01);
      tick();
      checks++; if (bus.ccr !== 4'b0101) begin errors++; $display("[TB] FAIL zero_set: got %b expected 0101", bus.ccr); end
      idle_inputs();
      bus.btype = 2'd1; bus.ra = 2'd0; bus.rb = 2'd3;
      bus.exmem_we = 1'b1; bus.exmem_rd = 2'd3; bus.exmem_val = 8'h3C;
      #1;
      checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL cond_taken: got %b expected 1", bus.branch_taken); end
      checks++; if (bus.branch_target !== 8'h3C) begin errors++; $display("[TB] FAIL cond_target: got %h expected 3C", bus.branch_target); end
      checks++; if (bus.flush_req !== 1'b1) begin errors++; $display("[TB] FAIL cond_flush: got %b expected 1", bus.flush_req); end
      tick();
      checks++; if (bus.ccr !== 4'b0100) begin errors++; $display("[TB] FAIL cond_clear: got %b expected 0100", bus.ccr); end
      checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL cond_not_taken: got %b expected 0", bus.branch_taken); end
      checks++; if (bus.branch_target !== 8'h00) begin errors++; $display("[TB] FAIL not_taken_target: got %h expected 00", bus.branch_target); end
      bus.ra = 2'd2; bus.alu_op = ALU_OP_SETC; bus.ra_val = 8'h00; bus.update_flags = 1'b1;
      #1;
      checks++; if (bus.branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL cond_c_taken: got %b expected 1", bus.branch_taken); end
      tick();
      checks++; if (bus.ccr !== 4'b0001) begin errors++; $display("[TB] FAIL update_then_clear: got %b expected 0001", bus.ccr); end
      idle_inputs();
      bus.btype = 2'd2; bus.rb = 2'd1; bus.rb_val = 8'h5A;
      #1;
      checks++; if (bus.branch_target !== 8'h5A || bus.branch_taken !== 1'b1) begin errors++; $display("[TB] FAIL uncond: got taken=%b target=%h expected 1/5A", bus.branch_taken, bus.branch_target); end
      tick();
      checks++; if (bus.ccr !== 4'b0001) begin errors++; $display("[TB] FAIL uncond_ccr: got %b expected 0001", bus.ccr); end
      bus.btype = 2'd3;
      #1;
      checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL reserved_btype: got %b expected 0", bus.branch_taken); end
      tick();
   endtask

   task automatic test_interrupt();
      do_add(8'hFF, 8'h01);
      tick();
      do_add(8'h01, 8'h90); bus.int_save = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'b0010) begin errors++; $display("[TB] FAIL isr_flags: got %b expected 0010", bus.ccr); end
      idle_inputs(); bus.rti_restore = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'b0101) begin errors++; $display("[TB] FAIL rti_restore: got %b expected 0101", bus.ccr); end
      do_add(8'h01, 8'h90);
      tick();
      idle_inputs(); bus.int_save = 1'b1; bus.rti_restore = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'b0101) begin errors++; $display("[TB] FAIL swap_ccr: got %b expected 0101", bus.ccr); end
      idle_inputs(); bus.rti_restore = 1'b1;
      tick();
      checks++; if (bus.ccr !== 4'b0010) begin errors++; $display("[TB] FAIL swap_shadow: got %b expected 0010", bus.ccr); end
   endtask

   task automatic test_bubble();
      logic [3:0] held;
      held = m_ccr;
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         bus.alu_op = 4'($urandom_range(0, 15)); bus.ra_val = 8'($urandom); bus.rb_val = 8'($urandom);
         bus.imm = 8'($urandom); bus.ra = 2'($urandom); bus.rb = 2'($urandom);
         #1;
         checks++; if (bus.branch_taken !== 1'b0) begin errors++; $display("[TB] FAIL bubble_taken: got %b expected 0", bus.branch_taken); end
         tick();
         checks++; if (bus.ccr !== held) begin errors++; $display("[TB] FAIL bubble_ccr: got %b expected %b", bus.ccr, held); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         bus.alu_op = 4'($urandom_range(0, 15)); bus.alu_src = 1'($urandom);
         bus.update_flags = 1'($urandom); bus.btype = 2'($urandom);
         bus.ra_val = 8'($urandom); bus.rb_val = 8'($urandom); bus.imm = 8'($urandom);
         bus.ra = 2'($urandom); bus.rb = 2'($urandom);
         bus.exmem_we = 1'($urandom); bus.exmem_rd = 2'($urandom); bus.exmem_val = 8'($urandom);
         bus.memwb_we = 1'($urandom); bus.memwb_rd = 2'($urandom); bus.memwb_val = 8'($urandom);
         bus.int_save = ($urandom_range(0, 7) == 0); bus.rti_restore = ($urandom_range(0, 7) == 0);
         #1;
         checks++; if (int'(bus.alu_result) !== exp_result()) begin errors++; $display("[TB] FAIL rand_result op=%h: got %h expected %h", bus.alu_op, bus.alu_result, exp_result()); end
         checks++; if (int'(bus.store_data) !== exp_fwd(int'(bus.rb), int'(bus.rb_val))) begin errors++; $display("[TB] FAIL rand_store: got %h expected %h", bus.store_data, exp_fwd(int'(bus.rb), int'(bus.rb_val))); end
         checks++; if (bus.branch_taken !== exp_taken() || bus.flush_req !== exp_taken()) begin errors++; $display("[TB] FAIL rand_taken: got %b/%b expected %b", bus.branch_taken, bus.flush_req, exp_taken()); end
         checks++; if (int'(bus.branch_target) !== (exp_taken() ? exp_fwd(int'(bus.rb), int'(bus.rb_val)) : 0)) begin errors++; $display("[TB] FAIL rand_target: got %h", bus.branch_target); end
         tick();
         checks++; if (bus.ccr !== m_ccr) begin errors++; $display("[TB] FAIL rand_ccr: got %b expected %b", bus.ccr, m_ccr); end
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_arith();
      test_branch();
      test_interrupt();
      test_bubble();
      test_random();
      idle_inputs();
      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
